// File: rtl/debug_slave_cmd_pkg.sv
// Shared constants and queue entry layout for the debug slave command queue.
package debug_slave_cmd_pkg;

    localparam int CMD_DATA_W      = 38;
    localparam int CMD_IR_W        = 2;
    localparam int CMD_DEPTH       = 4;
    localparam int CMD_SYNC_STAGES = 2;

    typedef struct packed {
        logic [CMD_IR_W-1:0]   ir;
        logic [CMD_DATA_W-1:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/debug_slave_cmd_queue_if.sv
// Command handshake between the debug slave queue (master) and its consumer (slave).
interface debug_slave_cmd_queue_if
    import debug_slave_cmd_pkg::*;
#(
    parameter int DATA_W = CMD_DATA_W,
    parameter int IR_W   = CMD_IR_W
);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [DATA_W-1:0]    jdo;
    logic [IR_W-1:0]      cmd_ir;
    logic [2**IR_W-1:0]   take_action;
    logic [2**IR_W-1:0]   take_no_action;

    modport master (
        output cmd_valid, jdo, cmd_ir, take_action, take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, jdo, cmd_ir, take_action, take_no_action,
        output cmd_ready
    );

endinterface

// File: rtl/debug_slave_strobe_sync.sv
// Synchronizes an asynchronous level strobe and emits one registered pulse per rising edge.
module debug_slave_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic event_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] fill_reg;
    logic                   prev_reg;
    logic                   armed_reg;

    // fill_reg tracks when sync_reg reflects the real input after reset; edges are
    // only honoured once the strobe has been seen low, so a strobe held high across
    // reset release is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg    <= '0;
            fill_reg    <= '0;
            prev_reg    <= 1'b0;
            armed_reg   <= 1'b0;
            event_pulse <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], strobe};
            fill_reg    <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
            prev_reg    <= sync_reg[SYNC_STAGES-1];
            if (fill_reg[SYNC_STAGES-1] && !sync_reg[SYNC_STAGES-1]) begin
                armed_reg <= 1'b1;
            end
            event_pulse <= armed_reg && sync_reg[SYNC_STAGES-1] && !prev_reg;
        end
    end

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Debug slave command queue: synchronizes exit1-DR/update-IR strobes, queues {ir, sr}
// commands and decodes the head into take_action/take_no_action. Optional macro: DEBUG_CMD_PARITY_EN.
module debug_slave_cmd_queue
    import debug_slave_cmd_pkg::*;
#(
    parameter int DATA_W      = CMD_DATA_W,
    parameter int IR_W        = CMD_IR_W,
    parameter int DEPTH       = CMD_DEPTH,
    parameter int SYNC_STAGES = CMD_SYNC_STAGES,
    parameter int ACT_BIT     = DATA_W - 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_W-1:0]       sr,
    input  logic [IR_W-1:0]         ir_in,
    input  logic                    vs_e1dr,
    input  logic                    vs_uir,
    input  logic                    ovf_clr,
`ifdef DEBUG_CMD_PARITY_EN
    input  logic                    sr_par,
    output logic                    par_err,
`endif
    debug_slave_cmd_queue_if.master cmd,
    output logic                    ir_upd,
    output logic [IR_W-1:0]         cur_ir,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic e1dr_evt;
    logic uir_evt;

    debug_slave_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_e1dr_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .strobe      (vs_e1dr),
        .event_pulse (e1dr_evt)
    );

    debug_slave_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .strobe      (vs_uir),
        .event_pulse (uir_evt)
    );

    entry_t              mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [LVL_W-1:0]    level_reg;
    logic                overflow_reg;
    logic                ir_upd_reg;
    logic [IR_W-1:0]     cur_ir_reg;
    logic [2**IR_W-1:0]  take_action_next;
    logic [2**IR_W-1:0]  take_no_action_next;
    entry_t              head;
    logic                cmd_valid;
    logic                full;
    logic                pop;
    logic                par_ok;
    logic                push_ok;
    logic                push;
    logic                drop;

`ifdef DEBUG_CMD_PARITY_EN
    assign par_ok = ((^sr) == sr_par);
`else
    assign par_ok = 1'b1;
`endif

    assign cmd_valid = (level_reg != '0);
    assign full      = (level_reg == LVL_W'(DEPTH));
    assign pop       = cmd_valid && cmd.cmd_ready;
    assign push_ok   = e1dr_evt && par_ok;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push      = push_ok && (!full || pop);
    assign drop      = push_ok && full && !pop;
    assign head      = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {ir_in, sr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            ir_upd_reg   <= 1'b0;
            cur_ir_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
            // A new drop wins over a simultaneous clear so no loss goes unreported.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
            ir_upd_reg <= uir_evt;
            if (uir_evt) begin
                cur_ir_reg <= ir_in;
            end
        end
    end

`ifdef DEBUG_CMD_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err <= 1'b0;
        end else if (e1dr_evt && !par_ok) begin
            par_err <= 1'b1;
        end else if (ovf_clr) begin
            par_err <= 1'b0;
        end
    end
`endif

    always_comb begin
        take_action_next    = '0;
        take_no_action_next = '0;
        if (pop) begin
            if (head.data[ACT_BIT]) begin
                take_action_next[head.ir] = 1'b1;
            end else begin
                take_no_action_next[head.ir] = 1'b1;
            end
        end
    end

    // Memory contents are not reset, so the head is masked while the queue is empty.
    assign cmd.cmd_valid      = cmd_valid;
    assign cmd.jdo            = cmd_valid ? head.data : '0;
    assign cmd.cmd_ir         = cmd_valid ? head.ir : '0;
    assign cmd.take_action    = take_action_next;
    assign cmd.take_no_action = take_no_action_next;

    assign ir_upd   = ir_upd_reg;
    assign cur_ir   = cur_ir_reg;
    assign level    = level_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Scoreboard bench for debug_slave_cmd_queue; honours DEBUG_CMD_PARITY_EN when defined.
module tb_debug_slave_cmd_queue;
    import debug_slave_cmd_pkg::*;

    localparam int DATA_W = CMD_DATA_W;
    localparam int IR_W   = CMD_IR_W;
    localparam int DEPTH  = CMD_DEPTH;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [DATA_W-1:0]      sr = '0;
    logic [IR_W-1:0]        ir_in = '0;
    logic                   vs_e1dr = 1'b0;
    logic                   vs_uir = 1'b0;
    logic                   ovf_clr = 1'b0;
    logic                   cmd_ready = 1'b0;
    logic                   ir_upd;
    logic [IR_W-1:0]        cur_ir;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
`ifdef DEBUG_CMD_PARITY_EN
    logic                   sr_par = 1'b0;
    logic                   par_err;
    bit                     bad_par = 1'b0;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;
    cmd_entry_t exp_q[$];

    always #5 clk = ~clk;

    debug_slave_cmd_queue_if #(.DATA_W(DATA_W), .IR_W(IR_W)) cmd_if ();
    assign cmd_if.cmd_ready = cmd_ready;

    debug_slave_cmd_queue #(.DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sr       (sr),
        .ir_in    (ir_in),
        .vs_e1dr  (vs_e1dr),
        .vs_uir   (vs_uir),
        .ovf_clr  (ovf_clr),
`ifdef DEBUG_CMD_PARITY_EN
        .sr_par   (sr_par),
        .par_err  (par_err),
`endif
        .cmd      (cmd_if),
        .ir_upd   (ir_upd),
        .cur_ir   (cur_ir),
        .level    (level),
        .overflow (overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: checks every pop against the scoreboard and idle cycles for stray pulses.
    initial begin
        cmd_entry_t         e;
        logic [2**IR_W-1:0] oh;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pop", 1, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = '0;
                        oh[e.ir] = 1'b1;
                        chk("pop_jdo", cmd_if.jdo, e.data);
                        chk("pop_ir", cmd_if.cmd_ir, e.ir);
                        chk("pop_take_action", cmd_if.take_action, e.data[DATA_W-1] ? oh : '0);
                        chk("pop_take_no_action", cmd_if.take_no_action, e.data[DATA_W-1] ? '0 : oh);
                        $display("pop ir=%0d jdo=0x%0h", cmd_if.cmd_ir, cmd_if.jdo);
                    end
                end else begin
                    chk("idle_pulses", {cmd_if.take_action, cmd_if.take_no_action}, 0);
                    if (cmd_if.cmd_valid && exp_q.size() != 0) begin
                        chk("hold_jdo", cmd_if.jdo, exp_q[0].data);
                        chk("hold_ir", cmd_if.cmd_ir, exp_q[0].ir);
                    end
                end
            end
        end
    end

    // One e1dr strobe (optionally with uir); ovf_clr/cmd_ready can be pulsed for the push cycle only.
    task automatic send(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] data, input bit uir,
                        input bit clr, input bit rdy_at_push, input bit expect_push, input bit chk_lat);
        cmd_entry_t e;
        e.ir   = ir;
        e.data = data;
        if (expect_push) exp_q.push_back(e);
        $display("send ir=%0d sr=0x%0h uir=%0b expect_push=%0b", ir, data, uir, expect_push);
        @(posedge clk);
        #1;
        ir_in   = ir;
        sr      = data;
`ifdef DEBUG_CMD_PARITY_EN
        sr_par  = (^data) ^ bad_par;
`endif
        vs_e1dr = 1'b1;
        vs_uir  = uir;
        step(3);
        if (clr) ovf_clr = 1'b1;
        if (rdy_at_push) cmd_ready = 1'b1;
        if (chk_lat) chk("latency_not_yet", cmd_if.cmd_valid, 0);
        step(1);
        ovf_clr = 1'b0;
        if (rdy_at_push) cmd_ready = 1'b0;
        vs_e1dr = 1'b0;
        vs_uir  = 1'b0;
        if (chk_lat) chk("latency_valid", cmd_if.cmd_valid, 1);
        if (uir) begin
            chk("ir_upd_pulse", ir_upd, 1);
            chk("cur_ir_load", cur_ir, ir);
        end
        step(1);
        if (uir) chk("ir_upd_one_cycle", ir_upd, 0);
        step(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_valid", cmd_if.cmd_valid, 0);
        chk("rst_jdo", cmd_if.jdo, 0);
        chk("rst_cmd_ir", cmd_if.cmd_ir, 0);
        chk("rst_ir_upd", ir_upd, 0);
        chk("rst_cur_ir", cur_ir, 0);
        chk("rst_pulses", {cmd_if.take_action, cmd_if.take_no_action}, 0);
        reset_n = 1'b1;
        step(6);

        // Single command, consumer ready: take_action bit 2.
        cmd_ready = 1'b1;
        send(2'd2, 38'h20_0000_0001, 0, 0, 0, 1, 1);
        step(2);
        chk("level_after_single", level, 0);

        // Fill past depth with consumer stalled.
        cmd_ready = 1'b0;
        send(2'd0, 38'h20_0000_00A0, 0, 0, 0, 1, 1);
        send(2'd1, 38'h00_0000_00B1, 0, 0, 0, 1, 0);
        send(2'd2, 38'h3F_0000_00C2, 0, 0, 0, 1, 0);
        send(2'd3, 38'h1F_FFFF_FFFF, 0, 0, 0, 1, 0);
        step(1);
        chk("level_full", level, 4);
        chk("overflow_before_drop", overflow, 0);
        send(2'd0, 38'h2A_AAAA_AAAA, 0, 0, 0, 0, 0);
        step(1);
        chk("level_after_drop", level, 4);
        chk("overflow_set", overflow, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("overflow_cleared", overflow, 0);

        // Drop coinciding with ovf_clr keeps overflow set.
        send(2'd3, 38'h15_5555_5555, 0, 1, 0, 0, 0);
        step(1);
        chk("overflow_clr_vs_drop", overflow, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("overflow_cleared2", overflow, 0);

        // Push and pop together while full.
        send(2'd1, 38'h3F_FFFF_FFFF, 0, 0, 1, 1, 0);
        step(1);
        chk("level_push_pop_full", level, 4);
        chk("overflow_push_pop_full", overflow, 0);

        // Drain; then pop on empty must be ignored.
        cmd_ready = 1'b1;
        step(8);
        chk("level_drained", level, 0);
        chk("valid_drained", cmd_if.cmd_valid, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        step(3);
        chk("level_pop_empty", level, 0);

        // Simultaneous update-IR and exit1-DR.
        cmd_ready = 1'b0;
        chk("cur_ir_before_uir", cur_ir, 0);
        send(2'd1, 38'h00_0000_00AA, 1, 0, 0, 1, 1);
        chk("level_after_uir_push", level, 1);
        send(2'd3, 38'h20_0000_0033, 1, 0, 0, 1, 0);
        chk("level_after_uir_push2", level, 2);
        cmd_ready = 1'b1;
        step(4);
        chk("level_after_uir_drain", level, 0);

        // Reset mid-operation with a strobe held across release.
        cmd_ready = 1'b0;
        send(2'd0, 38'h00_0000_0001, 0, 0, 0, 1, 0);
        send(2'd1, 38'h00_0000_0002, 0, 0, 0, 1, 0);
        send(2'd2, 38'h00_0000_0003, 0, 0, 0, 1, 0);
        chk("level_three", level, 3);
        sr      = 38'h00_0000_0004;
        ir_in   = 2'd3;
        vs_e1dr = 1'b1;
        step(1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_level", level, 0);
        chk("async_rst_valid", cmd_if.cmd_valid, 0);
        chk("async_rst_jdo", cmd_if.jdo, 0);
        chk("async_rst_cmd_ir", cmd_if.cmd_ir, 0);
        chk("async_rst_cur_ir", cur_ir, 0);
        chk("async_rst_overflow", overflow, 0);
        step(2);
        reset_n = 1'b1;
        step(10);
        chk("no_push_after_release", level, 0);
        chk("no_valid_after_release", cmd_if.cmd_valid, 0);
        vs_e1dr = 1'b0;
        step(4);
        send(2'd2, 38'h20_0000_0055, 0, 0, 0, 1, 1);
        chk("level_after_recover", level, 1);
        cmd_ready = 1'b1;
        step(3);
        chk("level_recover_drained", level, 0);

`ifdef DEBUG_CMD_PARITY_EN
        cmd_ready = 1'b0;
        bad_par = 1'b1;
        send(2'd0, 38'h00_0000_0001, 0, 0, 0, 0, 0);
        chk("par_drop_level", level, 0);
        chk("par_err_set", par_err, 1);
        bad_par = 1'b0;
        send(2'd0, 38'h00_0000_0001, 0, 0, 0, 1, 1);
        chk("par_ok_level", level, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("par_err_cleared", par_err, 0);
        cmd_ready = 1'b1;
        step(3);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/debug_slave_cmd_queue.md
DEBUG_SLAVE_CMD_QUEUE -- requirements
Module: debug_slave_cmd_queue

Interface
REQ-001 Parameter DATA_W, default 38: width of debug shift-register data / jdo.
REQ-002 Parameter IR_W, default 2: width of debug instruction register; 2**IR_W action channels.
REQ-003 Parameter DEPTH, default 4: command queue depth, power of 2, >=2.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer flops on strobes, >=2.
REQ-005 Parameter ACT_BIT, default DATA_W-1: jdo bit selecting take_action vs take_no_action.
REQ-006 The design SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; reset_n in 1, async active-low reset.
REQ-007 sr  in  DATA_W  debug shift-register contents; stable while strobes are high.
REQ-008 ir_in  in  IR_W  debug instruction register; stable while strobes are high.
REQ-009 vs_e1dr  in  1  exit1-DR strobe, asynchronous to clk, high >= SYNC_STAGES+1 clk cycles.
REQ-010 vs_uir  in  1  update-IR strobe, same timing rules as vs_e1dr.
REQ-011 cmd_ready  in  1  consumer accepts the head command.
REQ-012 ovf_clr  in  1  clears the sticky overflow flag.
REQ-013 jdo  out  DATA_W  data of the head entry.
REQ-014 cmd_ir  out  IR_W  IR of the head entry; cmd_valid  out  1  queue non-empty.
REQ-015 take_action  out  2**IR_W, and take_no_action  out  2**IR_W: one-hot, one-cycle pulses.
REQ-016 ir_upd  out  1: one-cycle pulse. cur_ir  out  IR_W: last IR latched on update-IR.
REQ-017 level  out  $clog2(DEPTH)+1  entry count; overflow  out  1  sticky drop flag.

Function
REQ-018 Each strobe SHALL pass through a SYNC_STAGES-flop synchronizer and then rising-edge detection; level-high strobes SHALL produce exactly one event.
REQ-019 An e1dr event SHALL push {ir_in, sr} into the FIFO; if the FIFO was empty, cmd_valid SHALL rise SYNC_STAGES+1 clk edges after the edge that first samples vs_e1dr high.
REQ-020 A uir event SHALL pulse ir_upd for one cycle and load cur_ir from ir_in in the same cycle.
REQ-021 Pop SHALL occur on cmd_valid && cmd_ready; in that same cycle, bit cmd_ir of take_action SHALL be driven if jdo[ACT_BIT]=1, otherwise that bit of take_no_action; all other bits SHALL be 0.
REQ-022 jdo and cmd_ir SHALL be driven from the head entry (show-ahead) and SHALL hold their value while cmd_valid && !cmd_ready.
REQ-023 Push while full and no pop: entry dropped, contents unchanged, overflow set the next cycle.
REQ-024 Push and pop in the same cycle while full: both SHALL succeed; level unchanged, no overflow.
REQ-025 Pop while empty SHALL be ignored; cmd_valid=0 and all action pulses 0.
REQ-026 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-027 ovf_clr SHALL clear overflow; simultaneous ovf_clr and a new drop SHALL leave overflow set.
REQ-028 Simultaneous e1dr and uir events SHALL both be processed in the same cycle.

Reset
REQ-029 reset_n low SHALL asynchronously clear synchronizers, edge registers, pointers, level, overflow, cur_ir, jdo, cmd_ir, cmd_valid, ir_upd and all action pulses to 0.
REQ-030 Reset mid-operation SHALL discard queued entries; a strobe held high across reset release SHALL NOT produce an event.

Configuration
REQ-031 Macro DEBUG_CMD_PARITY_EN: when defined, add inputs sr_par in 1 (even parity over sr) and output par_err out 1 (sticky, cleared by ovf_clr). A push with ^sr != sr_par SHALL be dropped and set par_err. When undefined, neither port exists and no parity check is performed.

Structure
REQ-032 Package debug_slave_cmd_pkg SHALL hold the default DATA_W/IR_W/DEPTH constants and the queue entry typedef {ir, data}.
REQ-033 Sub-module debug_slave_strobe_sync SHALL implement the synchronizer and rising-edge detector; it SHALL be instantiated once per strobe.

Verification
REQ-034 ir_in=2, sr=0x20_0000_0001, vs_e1dr high 4 cycles, cmd_ready=1 -> take_action=4'b0100 for one cycle, jdo=0x20_0000_0001, then level=0.
REQ-035 cmd_ready=0, 5 e1dr events, DEPTH=4 -> level=4, overflow=1, the 4 earliest entries pop in order; ovf_clr -> overflow=0.
REQ-036 Queue full, cmd_ready=1 and a new e1dr event in the same cycle -> level stays 4, overflow stays 0.
REQ-037 vs_uir and vs_e1dr rising together, ir_in=1 -> ir_upd pulse, cur_ir=1, entry with cmd_ir=1 pushed.
REQ-038 Assert reset_n=0 with 3 entries queued and vs_e1dr held high through reset release -> all outputs 0, no push after release.
REQ-039 With DEBUG_CMD_PARITY_EN: sr=0x1, sr_par=0 -> no push, par_err=1; sr_par=1 -> push.
